// File: rtl/grid_scanner.sv
// grid_scanner: multiplexed row scanner for a 16x16 bi-colour LED grid.
//
// Each frame begins with a one-cycle LATCH.
// LATCH snapshots the live grid and the cursor settings.
// Each of the 16 rows is then shown for DWELL cycles.
// Every row is preceded by BLANK_CYC blank cycles so that row ghosting cannot occur.
// The cursor overlays the red plane and blinks every BLINK_FRAMES frames.
// A frame that has started always runs to completion.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset (0 = in reset)
//   grid         live cell state, grid[r][c], 1 = alive
//   scan_en      1 = keep scanning frames
//   cursor_en    1 = overlay the cursor
//   cursor_row   cursor row, >15 = no cursor
//   cursor_col   cursor column, >15 = no cursor
//   row_drive    one-hot active-high row select
//   col_green    green column data for the driven row
//   col_red      red column data for the driven row (cursor)
//   row_idx      current row number
//   frame_start  one-cycle pulse during LATCH
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | outputs dark, waiting for scan_en
// LATCH | one cycle: snapshot grid/cursor, advance blink, row 0
// BLANK | BLANK_CYC cycles dark before the current row
// SHOW  | DWELL cycles driving the current row

module grid_scanner #(
  parameter int DWELL        = 64,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0][15:0] grid,
  input  logic              scan_en,
  input  logic              cursor_en,
  input  logic [7:0]        cursor_row,
  input  logic [7:0]        cursor_col,
  output logic [15:0]       row_drive,
  output logic [15:0]       col_green,
  output logic [15:0]       col_red,
  output logic [3:0]        row_idx,
  output logic              frame_start
);

  // Down-counters load N-1 and finish on zero, so N-1 must fit in each width.
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW_W-1:0] DW_LOAD = DW_W'(DWELL - 1);
  localparam logic [BK_W-1:0] BK_LOAD = BK_W'(BLANK_CYC - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, LATCH, BLANK, SHOW} state_t;

  state_t            state, state_n;
  logic [3:0]        row_n;
  logic [15:0][15:0] snap, snap_n;
  logic              cur_en, cur_en_n;
  logic [7:0]        cur_row, cur_row_n;
  logic [7:0]        cur_col, cur_col_n;
  logic [FC_W-1:0]   fcnt, fcnt_n;
  logic              blink, blink_n;
  logic [DW_W-1:0]   dwell_cnt, dwell_n;
  logic [BK_W-1:0]   blank_cnt, blank_n;

  logic [15:0]       drive_n, green_n, red_n;
  logic              fs_n;
  logic              red_hit;

  always_comb begin
    state_n   = state;
    row_n     = row_idx;
    snap_n    = snap;
    cur_en_n  = cur_en;
    cur_row_n = cur_row;
    cur_col_n = cur_col;
    fcnt_n    = fcnt;
    blink_n   = blink;
    dwell_n   = dwell_cnt;
    blank_n   = blank_cnt;

    case (state)
      IDLE: begin
        if (scan_en) begin
          state_n = LATCH;
          row_n   = 4'd0;
        end
      end

      LATCH: begin
        snap_n    = grid;
        cur_en_n  = cursor_en;
        cur_row_n = cursor_row;
        cur_col_n = cursor_col;
        // The blink toggled here is already the one used by this frame's rows.
        if (fcnt == FC_LAST) begin
          fcnt_n  = '0;
          blink_n = ~blink;
        end else begin
          fcnt_n = fcnt + FC_W'(1);
        end
        state_n = BLANK;
        blank_n = BK_LOAD;
      end

      BLANK: begin
        if (blank_cnt == '0) begin
          state_n = SHOW;
          dwell_n = DW_LOAD;
        end else begin
          blank_n = blank_cnt - BK_W'(1);
        end
      end

      SHOW: begin
        if (dwell_cnt == '0) begin
          if (row_idx != 4'd15) begin
            row_n   = row_idx + 4'd1;
            state_n = BLANK;
            blank_n = BK_LOAD;
          end else if (scan_en) begin
            state_n = LATCH;
            row_n   = 4'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          dwell_n = dwell_cnt - DW_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // The output registers are loaded from the next-state values.
  // This makes each output line up with the state the FSM is entering.
  // Outputs never depend combinationally on a port.
  always_comb begin
    drive_n = '0;
    green_n = '0;
    red_n   = '0;
    fs_n    = (state_n == LATCH);
    red_hit = cur_en_n && blink_n && (cur_row_n == {4'h0, row_n}) &&
              (cur_col_n[7:4] == 4'h0);
    if (state_n == SHOW) begin
      drive_n = 16'h0001 << row_n;
      green_n = snap_n[row_n];
      if (red_hit) begin
        red_n = 16'h0001 << cur_col_n[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      row_idx     <= 4'd0;
      snap        <= '0;
      cur_en      <= 1'b0;
      cur_row     <= 8'd0;
      cur_col     <= 8'd0;
      fcnt        <= '0;
      blink       <= 1'b1;
      dwell_cnt   <= '0;
      blank_cnt   <= '0;
      row_drive   <= '0;
      col_green   <= '0;
      col_red     <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      row_idx     <= row_n;
      snap        <= snap_n;
      cur_en      <= cur_en_n;
      cur_row     <= cur_row_n;
      cur_col     <= cur_col_n;
      fcnt        <= fcnt_n;
      blink       <= blink_n;
      dwell_cnt   <= dwell_n;
      blank_cnt   <= blank_n;
      row_drive   <= drive_n;
      col_green   <= green_n;
      col_red     <= red_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: doc/grid_scanner.md
GRID_SCANNER -- requirements
Module: grid_scanner

Interface
REQ-001 Parameters SHALL be: DWELL, default 64, SHOW cycles per row (>=1); BLANK_CYC, default 2, BLANK cycles before each row (>=1); BLINK_FRAMES, default 30, frames per cursor blink phase (>=1).
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  input  1  single clock, all state on rising edge
  reset  input  1  asynchronous, active-low; 0 = reset asserted
  grid  input  [15:0][15:0]  live cell state, grid[r][c], 1 = alive
  scan_en  input  1  1 = run display scan
  cursor_en  input  1  1 = overlay cursor
  cursor_row  input  8  cursor row; >15 = no cursor
  cursor_col  input  8  cursor column; >15 = no cursor
  row_drive  output  16  one-hot active-high row select
  col_green  output  16  green column data for driven row
  col_red  output  16  red column data for driven row
  row_idx  output  4  current row number
  frame_start  output  1  one-cycle pulse at each frame snapshot
REQ-003 Outputs SHALL be decoded only from registered state, with no combinational path from any input.

Function
REQ-004 FSM states SHALL be IDLE, LATCH, BLANK, SHOW.
REQ-005 IDLE: row_drive=0, col_green=0, col_red=0, frame_start=0; scan_en=1 at an edge -> LATCH.
REQ-006 LATCH lasts exactly one cycle: frame_start=1; snapshot register loads grid; cursor register loads {cursor_en, cursor_row, cursor_col}; row_idx loads 0; -> BLANK.
REQ-007 BLANK lasts BLANK_CYC cycles: row_drive=0, col_green=0, col_red=0; -> SHOW.
REQ-008 SHOW lasts DWELL cycles: row_drive=1<<row_idx; col_green=snapshot[row_idx]; col_red[c]=1 only when cursor snapshot enabled, cursor row==row_idx, cursor col==c, and blink=1.
REQ-009 SHOW end, row_idx<15 -> row_idx+1, BLANK; row_idx==15 -> LATCH if scan_en=1, else IDLE.
REQ-010 Frame length SHALL be 1+16*(BLANK_CYC+DWELL) cycles, with LATCH-to-LATCH spacing exact while scan_en stays 1.
REQ-011 scan_en falling mid-frame SHALL NOT abort the frame; the frame completes, then IDLE.
REQ-012 grid and cursor changes after LATCH SHALL NOT affect the displayed frame; the new values appear only from the next LATCH (tear-free).
REQ-013 Cursor coordinate >15, or cursor_en=0 at LATCH, SHALL give col_red=0 for the whole frame.
REQ-014 Live cell under the cursor SHALL drive both col_green and col_red bits (orange).
REQ-015 Blink: a frame counter counts LATCH events modulo BLINK_FRAMES; on wrap, blink toggles; new blink value applies from the same LATCH's frame.
REQ-016 Dwell and blank counters SHALL be sized for their parameter and SHALL NOT overflow; row_idx wraps only via LATCH.
REQ-017 At most one row_drive bit SHALL be 1 in any cycle.

Reset
REQ-018 reset=0 SHALL immediately, regardless of clk, force: state IDLE, all outputs 0, row_idx=0, snapshot=0, cursor snapshot=0, frame counter=0, blink=1.
REQ-019 reset asserted mid-frame SHALL blank the outputs at once; after release, operation resumes only via IDLE->LATCH.

Verification (DWELL=4, BLANK_CYC=1, BLINK_FRAMES=2 unless stated)
REQ-020 Reset, then scan_en=1 -> frame_start pulses one cycle after release, repeats every 81 cycles; row_drive steps 0x0001..0x8000, four cycles each, with one blank cycle of 0 before each row.
REQ-021 grid[8][7]=grid[8][8]=grid[9][8]=1 -> during row 8 SHOW col_green=0x0180; row 9 col_green=0x0100; all other rows 0.
REQ-022 grid changed to all-ones during row 3 of a frame -> rows 4..15 still show old data; next frame shows col_green=0xFFFF on every row.
REQ-023 cursor_en=1, cursor (8,8), grid[8][8]=1 -> frame 1: col_red=0x0100 and col_green=0x0100 in row 8; blink toggles every 2 frames; cursor_row=20 -> col_red=0 always.
REQ-024 scan_en dropped during row 5 -> frame completes through row 15, then IDLE with all outputs 0; reset pulsed low during row 10 -> outputs 0 asynchronously, no frame_start until release plus scan_en=1.
